// File: rtl/midi_pkg.sv
// ---------------------------------------------------------------------------
// midi_pkg
// Shared definitions for the MIDI note decoder:
//   - MIDI status nibbles (note off / note on / system)
//   - parser and receiver state encodings
//   - octave -1 square-wave periods at 50 MHz (BASE) and the note split helper
// ---------------------------------------------------------------------------
package midi_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] SYS      = 4'hF;

  typedef enum logic [1:0] {
    P_IDLE    = 2'd0,
    P_WAIT_D1 = 2'd1,
    P_WAIT_D2 = 2'd2,
    P_SKIP    = 2'd3
  } parse_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  typedef struct packed {
    logic [3:0] oct;
    logic [3:0] semi;
  } note_split_t;

  // Period of each semitone in octave -1, in 50 MHz cycles, rounded to nearest.
  localparam logic [31:0] BASE [12] = '{
    32'd6115610, 32'd5772367, 32'd5448389, 32'd5142595,
    32'd4853963, 32'd4581531, 32'd4324390, 32'd4081680,
    32'd3852593, 32'd3636364, 32'd3432270, 32'd3239632
  };

  function automatic logic [31:0] base_period(input logic [3:0] semi);
    logic [31:0] p;
    p = 32'd0;
    for (int i = 0; i < 12; i++) begin
      if (semi == 4'(i)) p = BASE[i];
    end
    return p;
  endfunction

  // Constant-divisor split of a 7-bit note number; reduces to a 128-entry table.
  function automatic note_split_t split_note(input logic [6:0] note);
    note_split_t s;
    s.oct  = 4'(note / 7'd12);
    s.semi = 4'(note % 7'd12);
    return s;
  endfunction

endpackage

// File: rtl/midi_note_decoder_if.sv
// ---------------------------------------------------------------------------
// midi_note_decoder_if
// Control side of the voice interface.
//   note_on / note_off : one-cycle strobes
//   gate               : high while a note is held
//   note, velocity     : last note-on note number and velocity
//   period             : square-wave period of note, in clk cycles
//   frame_err          : one-cycle strobe, stop bit sampled low
// master = decoder (drives), slave = note bank (receives).
// ---------------------------------------------------------------------------
interface midi_note_decoder_if;
  logic        note_on;
  logic        note_off;
  logic        gate;
  logic [6:0]  note;
  logic [6:0]  velocity;
  logic [31:0] period;
  logic        frame_err;

  modport master (output note_on, note_off, gate, note, velocity, period, frame_err);
  modport slave  (input  note_on, note_off, gate, note, velocity, period, frame_err);
endinterface

// File: rtl/midi_uart_rx.sv
// ---------------------------------------------------------------------------
// midi_uart_rx
// 8N1 serial receiver for the MIDI input pin.
//   clk, rst_b  : clock, asynchronous active-low reset
//   rx          : raw asynchronous serial line, idle high
//   byte_valid  : one-cycle strobe, byte_data holds a good byte
//   byte_data   : received byte (LSB first on the wire)
//   frame_err   : one-cycle strobe, stop bit sampled low, byte dropped
// ---------------------------------------------------------------------------
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1600
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic          sync1_q, sync2_q, prev_q;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        // prev_q resets low, so a line held low through reset is not taken as a start.
        if (prev_q && !sync2_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          bit_d = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = RX_STOP;
          else               bit_d   = bit_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          valid_d = sync2_q;
          ferr_d  = !sync2_q;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign byte_valid = valid_q;
  assign byte_data  = shift_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/midi_note_decoder.sv
// ---------------------------------------------------------------------------
// midi_note_decoder
// Decodes channel note-on / note-off messages from a serial MIDI stream into
// strobes, gate, note/velocity and a square-wave period for the note bank.
//   clk, rst_b : 50 MHz clock, asynchronous active-low reset
//   midi_rx    : raw MIDI input pin, idle high
//   voice      : midi_note_decoder_if.master (note_on, note_off, gate, note,
//                velocity, period, frame_err)
// Build option: define MIDI_RUNNING_STATUS_EN to keep the latched status
// after an event (running status); otherwise the parser returns to idle.
// ---------------------------------------------------------------------------
module midi_note_decoder
  import midi_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1600,
  parameter int unsigned CHANNEL      = 0
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 midi_rx,
  midi_note_decoder_if.master  voice
);

  localparam logic [3:0] CH = 4'(CHANNEL);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;

  midi_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst_b      (rst_b),
    .rx         (midi_rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  // Parser state
  parse_state_e state_q, state_d;
  logic         is_on_q, is_on_d;
  logic [6:0]   d1_q, d1_d;

  // Stage 1: event with note split registered
  logic         s1_valid_q, s1_valid_d;
  logic         s1_on_q, s1_on_d;
  logic [6:0]   s1_note_q, s1_note_d;
  logic [6:0]   s1_vel_q, s1_vel_d;
  note_split_t  s1_split_q, s1_split_d;

  // Stage 2: registered outputs
  logic         note_on_q, note_on_d;
  logic         note_off_q, note_off_d;
  logic         gate_q, gate_d;
  logic [6:0]   note_q, note_d;
  logic [6:0]   vel_q, vel_d;
  logic [31:0]  period_q, period_d;

  always_comb begin
    state_d     = state_q;
    is_on_d     = is_on_q;
    d1_d        = d1_q;
    s1_valid_d  = 1'b0;
    s1_on_d     = is_on_q;
    s1_note_d   = d1_q;
    s1_vel_d    = byte_data[6:0];
    s1_split_d  = split_note(d1_q);
    if (byte_valid) begin
      if (byte_data[7]) begin
        if (byte_data[7:4] == SYS) begin
          // F8-FF are real-time and fully transparent; F0-F7 cancel running status.
          if (!byte_data[3]) begin
            state_d = P_IDLE;
            is_on_d = 1'b0;
          end
        end else if ((byte_data[7:4] == NOTE_ON || byte_data[7:4] == NOTE_OFF) &&
                     byte_data[3:0] == CH) begin
          state_d = P_WAIT_D1;
          is_on_d = (byte_data[7:4] == NOTE_ON);
        end else begin
          state_d = P_SKIP;
        end
      end else begin
        unique case (state_q)
          P_WAIT_D1: begin
            d1_d    = byte_data[6:0];
            state_d = P_WAIT_D2;
          end
          P_WAIT_D2: begin
            s1_valid_d = 1'b1;
`ifdef MIDI_RUNNING_STATUS_EN
            state_d = P_WAIT_D1;
`else
            state_d = P_IDLE;
`endif
          end
          default: state_d = state_q;
        endcase
      end
    end
  end

  always_comb begin
    note_on_d  = 1'b0;
    note_off_d = 1'b0;
    gate_d     = gate_q;
    note_d     = note_q;
    vel_d      = vel_q;
    period_d   = period_q;
    if (s1_valid_q) begin
      if (s1_on_q && s1_vel_q != 7'd0) begin
        note_on_d = 1'b1;
        gate_d    = 1'b1;
        note_d    = s1_note_q;
        vel_d     = s1_vel_q;
        period_d  = base_period(s1_split_q.semi) >> s1_split_q.oct;
      end else if (gate_q && s1_note_q == note_q) begin
        // Release only the held note; note/velocity/period stay for the voice tail.
        note_off_d = 1'b1;
        gate_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= P_IDLE;
      is_on_q    <= 1'b0;
      d1_q       <= '0;
      s1_valid_q <= 1'b0;
      s1_on_q    <= 1'b0;
      s1_note_q  <= '0;
      s1_vel_q   <= '0;
      s1_split_q <= '0;
      note_on_q  <= 1'b0;
      note_off_q <= 1'b0;
      gate_q     <= 1'b0;
      note_q     <= '0;
      vel_q      <= '0;
      period_q   <= '0;
    end else begin
      state_q    <= state_d;
      is_on_q    <= is_on_d;
      d1_q       <= d1_d;
      s1_valid_q <= s1_valid_d;
      s1_on_q    <= s1_on_d;
      s1_note_q  <= s1_note_d;
      s1_vel_q   <= s1_vel_d;
      s1_split_q <= s1_split_d;
      note_on_q  <= note_on_d;
      note_off_q <= note_off_d;
      gate_q     <= gate_d;
      note_q     <= note_d;
      vel_q      <= vel_d;
      period_q   <= period_d;
    end
  end

  assign voice.note_on   = note_on_q;
  assign voice.note_off  = note_off_q;
  assign voice.gate      = gate_q;
  assign voice.note      = note_q;
  assign voice.velocity  = vel_q;
  assign voice.period    = period_q;
  assign voice.frame_err = frame_err;

endmodule

// File: tb/tb_midi_note_decoder.sv
// ---------------------------------------------------------------------------
// tb_midi_note_decoder
// Table-driven bench for midi_note_decoder with a shortened bit time, plus
// hand-written sequences for running status, real-time bytes, framing errors,
// start-bit glitches and reset in the middle of a frame.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_midi_note_decoder;

  localparam int CPB    = 16;
  // start-bit edge -> byte_valid (9.5 bits + 2 sync) -> split -> output register
  localparam int EV_LAT = 9 * CPB + CPB / 2 + 2 + 2;
`ifdef MIDI_RUNNING_STATUS_EN
  localparam bit RS = 1'b1;
`else
  localparam bit RS = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_b = 1'b0;
  logic midi_rx = 1'b1;

  always #10 clk = ~clk;

  midi_note_decoder_if voice();

  midi_note_decoder #(.CLKS_PER_BIT(CPB), .CHANNEL(0)) dut (
    .clk     (clk),
    .rst_b   (rst_b),
    .midi_rx (midi_rx),
    .voice   (voice)
  );

  int checks   = 0;
  int failures = 0;
  int cyc = 0, start_cyc = 0;
  int on_cnt = 0, off_cnt = 0, ferr_cnt = 0, bv_cnt = 0;
  int last_on_cyc = 0, last_off_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (voice.note_on)  begin on_cnt++;  last_on_cyc  = cyc; end
    if (voice.note_off) begin off_cnt++; last_off_cyc = cyc; end
    if (voice.frame_err) ferr_cnt++;
    if (dut.u_rx.byte_valid) bv_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop = 1'b1);
    @(negedge clk);
    midi_rx   = 1'b0;
    start_cyc = cyc + 1;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      midi_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    midi_rx = stop;
    repeat (CPB) @(negedge clk);
    midi_rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_msg(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    repeat (CPB) @(negedge clk);
  endtask

  task automatic check_outputs(input string tag, input logic g, input logic [6:0] n,
                               input logic [6:0] v, input logic [31:0] p);
    check({tag, " gate"},     32'(voice.gate),     32'(g));
    check({tag, " note"},     32'(voice.note),     32'(n));
    check({tag, " velocity"}, 32'(voice.velocity), 32'(v));
    check({tag, " period"},   voice.period,        p);
  endtask

  typedef struct {
    logic [7:0]  b0, b1, b2;
    int          n_on, n_off;
    logic        gate;
    logic [6:0]  note, vel;
    logic [31:0] period;
  } vec_t;

  localparam int NV = 18;
  vec_t v [NV];

  int on0, off0, ferr0, bv0;

  initial begin
    v[0]  = '{8'h90, 8'h45, 8'h64, 1, 0, 1'b1, 7'h45, 7'h64, 32'd113636};
    v[1]  = '{8'h80, 8'h3C, 8'h00, 0, 0, 1'b1, 7'h45, 7'h64, 32'd113636};
    v[2]  = '{8'h80, 8'h45, 8'h00, 0, 1, 1'b0, 7'h45, 7'h64, 32'd113636};
    v[3]  = '{8'h90, 8'h3C, 8'h7F, 1, 0, 1'b1, 7'h3C, 7'h7F, 32'd191112};
    v[4]  = '{8'h90, 8'h3C, 8'h00, 0, 1, 1'b0, 7'h3C, 7'h7F, 32'd191112};
    v[5]  = '{8'h91, 8'h45, 8'h64, 0, 0, 1'b0, 7'h3C, 7'h7F, 32'd191112};
    v[6]  = '{8'h90, 8'h45, 8'h64, 1, 0, 1'b1, 7'h45, 7'h64, 32'd113636};
    v[7]  = '{8'h90, 8'h3C, 8'h7F, 1, 0, 1'b1, 7'h3C, 7'h7F, 32'd191112};
    v[8]  = '{8'hA0, 8'h10, 8'h20, 0, 0, 1'b1, 7'h3C, 7'h7F, 32'd191112};
    v[9]  = '{8'h80, 8'h3C, 8'h40, 0, 1, 1'b0, 7'h3C, 7'h7F, 32'd191112};
    v[10] = '{8'h9F, 8'h45, 8'h64, 0, 0, 1'b0, 7'h3C, 7'h7F, 32'd191112};
    v[11] = '{8'h90, 8'h00, 8'h01, 1, 0, 1'b1, 7'h00, 7'h01, 32'd6115610};
    v[12] = '{8'h90, 8'h7F, 8'h7F, 1, 0, 1'b1, 7'h7F, 7'h7F, 32'd3986};
    v[13] = '{8'h90, 8'h15, 8'h50, 1, 0, 1'b1, 7'h15, 7'h50, 32'd1818182};
    v[14] = '{8'h80, 8'h15, 8'h00, 0, 1, 1'b0, 7'h15, 7'h50, 32'd1818182};
    v[15] = '{8'h90, 8'h0D, 8'h10, 1, 0, 1'b1, 7'h0D, 7'h10, 32'd2886183};
    v[16] = '{8'h90, 8'h2E, 8'h10, 1, 0, 1'b1, 7'h2E, 7'h10, 32'd429033};
    v[17] = '{8'h80, 8'h2E, 8'h00, 0, 1, 1'b0, 7'h2E, 7'h10, 32'd429033};

    // Reset state
    repeat (5) @(negedge clk);
    check("reset note_on",   32'(voice.note_on),   32'd0);
    check("reset note_off",  32'(voice.note_off),  32'd0);
    check("reset frame_err", 32'(voice.frame_err), 32'd0);
    check_outputs("reset", 1'b0, 7'd0, 7'd0, 32'd0);
    rst_b = 1'b1;
    repeat (4 * CPB) @(negedge clk);

    // Table-driven messages
    for (int i = 0; i < NV; i++) begin
      on0  = on_cnt;
      off0 = off_cnt;
      send_msg(v[i].b0, v[i].b1, v[i].b2);
      check($sformatf("v%0d note_on count", i),  32'(on_cnt - on0),   32'(v[i].n_on));
      check($sformatf("v%0d note_off count", i), 32'(off_cnt - off0), 32'(v[i].n_off));
      check_outputs($sformatf("v%0d", i), v[i].gate, v[i].note, v[i].vel, v[i].period);
      if (v[i].n_on != 0)
        check($sformatf("v%0d on latency", i), 32'(last_on_cyc - start_cyc), 32'(EV_LAT));
      if (v[i].n_off != 0)
        check($sformatf("v%0d off latency", i), 32'(last_off_cyc - start_cyc), 32'(EV_LAT));
    end

    // Running status: a bare data pair after an event
    send_msg(8'h90, 8'h3C, 8'h7F);
    on0 = on_cnt; off0 = off_cnt;
    send_byte(8'h3C);
    send_byte(8'h00);
    repeat (CPB) @(negedge clk);
    check("rs note_off count", 32'(off_cnt - off0), RS ? 32'd1 : 32'd0);
    check("rs note_on count",  32'(on_cnt - on0),   32'd0);
    check_outputs("rs", RS ? 1'b0 : 1'b1, 7'h3C, 7'h7F, 32'd191112);
    off0 = off_cnt;
    send_msg(8'h80, 8'h3C, 8'h00);
    check("rs cleanup note_off count", 32'(off_cnt - off0), RS ? 32'd0 : 32'd1);
    check("rs cleanup gate", 32'(voice.gate), 32'd0);

    // Real-time byte between the two data bytes is transparent
    on0 = on_cnt;
    send_byte(8'h90);
    send_byte(8'h45);
    send_byte(8'hF8);
    send_byte(8'h64);
    repeat (CPB) @(negedge clk);
    check("rt note_on count", 32'(on_cnt - on0), 32'd1);
    check("rt on latency", 32'(last_on_cyc - start_cyc), 32'(EV_LAT));
    check_outputs("rt", 1'b1, 7'h45, 7'h64, 32'd113636);
    send_msg(8'h80, 8'h45, 8'h00);
    check("rt release gate", 32'(voice.gate), 32'd0);

    // System common byte cancels the pending message
    on0 = on_cnt;
    send_byte(8'h90);
    send_byte(8'h45);
    send_byte(8'hF0);
    send_byte(8'h64);
    repeat (CPB) @(negedge clk);
    check("sys note_on count", 32'(on_cnt - on0), 32'd0);
    check("sys gate", 32'(voice.gate), 32'd0);

    // Framing error: strobe, byte dropped, parser keeps waiting for data 2
    send_byte(8'h90);
    send_byte(8'h45);
    on0 = on_cnt; ferr0 = ferr_cnt; bv0 = bv_cnt;
    send_byte(8'h12, 1'b0);
    repeat (CPB) @(negedge clk);
    check("ferr frame_err count", 32'(ferr_cnt - ferr0), 32'd1);
    check("ferr byte_valid count", 32'(bv_cnt - bv0), 32'd0);
    check("ferr note_on count", 32'(on_cnt - on0), 32'd0);
    send_byte(8'h64);
    repeat (CPB) @(negedge clk);
    check("ferr resume note_on count", 32'(on_cnt - on0), 32'd1);
    check_outputs("ferr resume", 1'b1, 7'h45, 7'h64, 32'd113636);
    send_msg(8'h80, 8'h45, 8'h00);

    // Short glitch on the line is rejected at the start-bit re-check
    bv0 = bv_cnt; ferr0 = ferr_cnt;
    @(negedge clk);
    midi_rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    midi_rx = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    check("glitch byte_valid count", 32'(bv_cnt - bv0), 32'd0);
    check("glitch frame_err count", 32'(ferr_cnt - ferr0), 32'd0);
    on0 = on_cnt;
    send_msg(8'h90, 8'h3C, 8'h7F);
    check("post glitch note_on count", 32'(on_cnt - on0), 32'd1);
    check_outputs("post glitch", 1'b1, 7'h3C, 7'h7F, 32'd191112);

    // Reset in the middle of a frame, line still low at release
    @(negedge clk);
    midi_rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    rst_b = 1'b0;
    #1;
    check("midreset note_on",  32'(voice.note_on),  32'd0);
    check("midreset note_off", 32'(voice.note_off), 32'd0);
    check_outputs("midreset", 1'b0, 7'd0, 7'd0, 32'd0);
    repeat (CPB) @(negedge clk);
    rst_b = 1'b1;
    bv0 = bv_cnt; ferr0 = ferr_cnt;
    repeat (2 * CPB) @(negedge clk);
    midi_rx = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    check("post reset byte_valid count", 32'(bv_cnt - bv0), 32'd0);
    check("post reset frame_err count", 32'(ferr_cnt - ferr0), 32'd0);
    on0 = on_cnt;
    send_msg(8'h90, 8'h45, 8'h64);
    check("post reset note_on count", 32'(on_cnt - on0), 32'd1);
    check("post reset on latency", 32'(last_on_cyc - start_cyc), 32'(EV_LAT));
    check_outputs("post reset", 1'b1, 7'h45, 7'h64, 32'd113636);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/midi_note_decoder.md
# midi_note_decoder

Receives a serial MIDI stream (31 250 baud, 8N1) and turns channel note messages into the single-cycle `note_on` / `note_off` strobes plus the `period` word that drive the monophonic note bank. It sits between the board's MIDI input pin and the synthesis voice. It supplies the control side of the voice interface whose audio side the note bank produces.

## Interface
- `CLKS_PER_BIT`, 1600: clk cycles per MIDI bit (50 MHz / 31 250).
- `CHANNEL`, 0: MIDI channel (0–15) accepted; all others ignored.
- `clk` in 1: system clock, 50 MHz. One clock; every flop is on its rising edge.
- `rst_b` in 1: reset, asynchronous, active-low.
- `midi_rx` in 1: raw serial input, asynchronous; idle high.
- `note_on` out 1: one-cycle strobe, new note started.
- `note_off` out 1: one-cycle strobe, held note released.
- `gate` out 1: high while a note is held.
- `note` out 7: note number of the last note-on.
- `velocity` out 7: velocity of the last note-on.
- `period` out 32: square-wave period of `note`, in clk cycles.
- `frame_err` out 1: one-cycle strobe, stop bit was sampled low.

## Operation
- **Receiver**
  - `midi_rx` passes through a 2-flop synchronizer.
  - A falling edge starts a frame. The start bit is re-checked at CLKS_PER_BIT/2; if the line is high there, it is a glitch and the receiver returns to idle.
  - 8 data bits are sampled LSB first at mid-bit. Then the stop bit is sampled.
  - Stop = 1: `byte_valid` pulses for one cycle with the byte.
  - Stop = 0: `frame_err` pulses and the byte is discarded.
- **Parser states:** IDLE, WAIT_D1, WAIT_D2, SKIP.
  - 0x8n/0x9n with n == CHANNEL: latch the status (off/on), go to WAIT_D1.
  - Any other 0x80–0xEF: go to SKIP.
  - 0xF0–0xF7: go to IDLE and clear the running status.
  - 0xF8–0xFF (real-time): ignored completely; state and data are unchanged. This applies even between two data bytes.
  - Data byte (bit7 = 0) in IDLE or SKIP: ignored.
  - Data byte in WAIT_D1: store the note number, go to WAIT_D2.
  - Data byte in WAIT_D2: store the velocity and issue an event. The next state is set by the configuration macro.
- **Events**
  - 0x9n with velocity > 0: update `note`, `velocity` and `period`; pulse `note_on`; set `gate`. A note-on while `gate` is high retriggers: `note_on` pulses, with no `note_off`.
  - 0x8n, or 0x9n with velocity 0: acts only if the note number equals `note` and `gate` = 1. In that case `note_off` pulses and `gate` clears. `note`, `velocity` and `period` are held. A non-matching note-off is dropped.
- **Period arithmetic**
  - The note is split as note = 12·oct + semi (oct 0–10), using a constant 128-entry lookup.
  - period = BASE[semi] >> oct.
  - BASE is the period of octave −1 at 50 MHz, rounded to nearest, 32-bit unsigned. BASE[0] = 6 115 610 (C−1) and BASE[9] = 3 636 364 (A−1).
  - The shift truncates.

## Timing
- **Reset values:** all outputs 0. Parser in IDLE, running status cleared, receiver idle.
- **Reset mid-frame:** the partial byte is lost. After release, the receiver waits for the line to be high before it arms edge detection.
- **Receiver latency:** `byte_valid` is raised 9.5·CLKS_PER_BIT + 2 (synchronizer) cycles after the start-bit falling edge.
- **Event latency:** the data-2 `byte_valid` is cycle 0. The split is registered at cycle 1 and the shift at cycle 2. `note_on`/`note_off` pulse at cycle 2, with `note`, `velocity`, `period` and `gate` valid in that same cycle.
- **Event spacing:** at most one event per byte, so strobes are always separated by ≥10·CLKS_PER_BIT cycles.
- **`frame_err` vs parser:** `frame_err` and `byte_valid` are mutually exclusive. A framing error does not change the parser state.

## Configuration
- `MIDI_RUNNING_STATUS_EN` defined: after an event the parser goes to WAIT_D1 and keeps the latched status. Further data pairs therefore reuse it (standard running status).
- `MIDI_RUNNING_STATUS_EN` undefined: after an event the parser goes to IDLE. Data bytes that arrive without a fresh status byte are ignored.

## Structure
- **Shared package `midi_pkg`**
  - BASE[0:11] period constants.
  - Status codes: NOTE_OFF = 4'h8, NOTE_ON = 4'h9, SYS = 4'hF.
  - Parser state encoding.
- **Sub-module `midi_uart_rx`** (parameter CLKS_PER_BIT)
  - Ports: clk, rst_b, rx, byte_valid, byte_data[7:0], frame_err.
  - Contains the synchronizer, bit counter and baud counter.
- **Top level:** parser FSM, note/velocity registers, and the period split/shift pipeline.

## Test plan
- Send 0x90 0x45 0x64 (CHANNEL = 0) → `note_on` 1 cycle, note = 69, velocity = 100, period = 113 636, gate = 1.
- Then send 0x80 0x45 0x00 → `note_off` 1 cycle, gate = 0, period stays 113 636. Send 0x80 0x3C 0x00 while 69 is held → no strobe.
- 0x90 0x3C 0x7F, then 0x3C 0x00 with no status byte:
  - with `MIDI_RUNNING_STATUS_EN`: period = 191 112, then `note_off`;
  - without it: the second pair is ignored and gate stays 1.
- 0x90 0x45, then 0xF8, then 0x64 → identical to the first test (real-time byte transparent).
- Send 0x91 0x45 0x64 → no strobe. Send a frame with stop bit = 0 → `frame_err` pulse, no parser change.
- Glitch on `midi_rx` shorter than CLKS_PER_BIT/2 → no byte. Assert `rst_b` mid-frame → all outputs 0 immediately; the next clean message decodes correctly.
